ex_mdu_stage: RTL
=================

EX_MDU_STAGE -- requirements
Module: ex_mdu_stage

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the operand/result width (minimum 4).
REQ-002 The block SHALL have parameter REG_DIR_WIDTH, default 3, giving the register-address width.
REQ-003 The block SHALL have parameter PC_WIDTH, default 6, giving the PC/branch-target width.

Interface
REQ-004 The clock, reset and stall ports SHALL be:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present at stage input.
- Stall  out  1  hold upstream stages this cycle.
REQ-005 The operand and forwarding ports SHALL be:
- readd1, readd2  in  DATA_WIDTH  register-file operands.
- Forward_A, Forward_B  in  2  operand source select.
- WBData, Address  in  DATA_WIDTH  WB-stage and MEM-stage forward values.
- SignExtendOut  in  DATA_WIDTH  immediate.
REQ-006 The control and addressing ports SHALL be:
- ALUSrc, RegDst  in  1  immediate select; destination select.
- RegDst1, RegDst2  in  REG_DIR_WIDTH  rd / rt candidates.
- ALUop  in  2  main-decoder op class.
- funct  in  6  R-type function field.
- PCnext  in  PC_WIDTH  PC+1.
REQ-007 The registered output ports SHALL be:
- out_valid  out  1  EX/MEM register holds a valid result.
- ALUResult  out  DATA_WIDTH  result.
- data2  out  DATA_WIDTH  forwarded rt value (store data).
- WriteReg  out  REG_DIR_WIDTH  destination register.
- Zero  out  1  ALUResult==0.
- ALUR  out  PC_WIDTH  branch target.
- HI  out  DATA_WIDTH  product high half / remainder.

Function
REQ-008 Forward_A/B 0,1,2,3 SHALL select readd, WBData, Address, and the current registered ALUResult respectively (3 is an EX-to-EX bypass).
REQ-009 Operand B SHALL be SignExtendOut when ALUSrc=1, otherwise forwarded data2; WriteReg SHALL be RegDst1 when RegDst=1, else RegDst2.
REQ-010 ALUop 00/01/11 SHALL perform add/sub/or; ALUop 10 SHALL decode funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0), 0x10 mfhi, 0x18 mult (unsigned), 0x1A div (unsigned).
REQ-011 Add/sub SHALL wrap modulo 2^DATA_WIDTH; undefined funct SHALL yield result 0.
REQ-012 ALUR SHALL be PCnext + SignExtendOut truncated to PC_WIDTH, registered with the result.
REQ-013 Single-cycle ops SHALL have latency 1: inputs are sampled at edge k when in_valid=1; outputs and out_valid=1 are valid after edge k; Stall=0.
REQ-014 When in_valid=0 in IDLE, out_valid SHALL be 0 after the edge; other outputs SHALL hold.
REQ-015 The FSM SHALL have states IDLE, BUSY, DONE with these transitions:
- IDLE -> BUSY on in_valid with mult/div; operands, WriteReg and PCnext are latched; counter is set to DATA_WIDTH.
- BUSY SHALL perform one shift-add (mult) or restoring-subtract (div) iteration per cycle and go to DONE when the counter reaches 0.
- DONE -> IDLE.
REQ-016 Stall SHALL be 1 in the IDLE acceptance cycle and in all BUSY cycles, and 0 in DONE; it totals DATA_WIDTH+1 cycles.
REQ-017 In DONE the held mult/div instruction SHALL be retired without re-acceptance:
- mult: ALUResult=low half, HI=high half.
- div: ALUResult=quotient, HI=remainder.
- out_valid=1 after the DONE edge.
REQ-018 Divide by zero SHALL give quotient all-ones and remainder = dividend, with no extra latency.
REQ-019 HI SHALL change only on mult/div completion or reset; out_valid SHALL be 0 while BUSY.

Reset
REQ-020 rst=1 at an edge SHALL force state IDLE, counter 0, and all outputs 0 (including HI, out_valid, Stall after the edge), aborting any mult/div in progress; rst SHALL take priority over in_valid.

Verification
REQ-021 ALUop=10, funct=0x20, readd1=5, readd2=3, Forward=0 -> after one edge: ALUResult=8, Zero=0, out_valid=1, Stall never high.
REQ-022 funct=0x18, operands 20 and 15 (DATA_WIDTH=8) -> Stall high exactly 9 cycles; then ALUResult=0x2C, HI=0x01, out_valid=1 for one cycle.
REQ-023 funct=0x1A, 100/7 -> ALUResult=14, HI=2; then 9/0 -> ALUResult=0xFF, HI=9.
REQ-024 Back-to-back add (result 8) then ALUSrc=1, SignExtendOut=4, Forward_A=3, ALUop=00 -> ALUResult=12; ALUop=01 with equal operands -> Zero=1; slt -3 vs 2 -> 1.
REQ-025 rst asserted in the 4th BUSY cycle of a mult -> after that edge: Stall=0, out_valid=0, HI=0; a following add completes normally.

Source files
------------

// File: rtl/ex_mdu_stage_if.sv
// ex_mdu_stage_if
//   Bundles the EX-stage handshake, operand, control and result signals of
//   ex_mdu_stage so the stage connects to the pipeline through one port.
//   master : the pipeline side (drives instruction fields, reads results)
//   slave  : the EX stage itself (reads instruction fields, drives results)
//   Stage inputs : in_valid, readd1, readd2, Forward_A, Forward_B, WBData,
//                  Address, SignExtendOut, ALUSrc, RegDst, RegDst1, RegDst2,
//                  ALUop, funct, PCnext
//   Stage outputs: Stall, out_valid, ALUResult, data2, WriteReg, Zero, ALUR, HI
interface ex_mdu_stage_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_DIR_WIDTH = 3,
  parameter int PC_WIDTH      = 6
);
  logic                     in_valid;
  logic                     Stall;
  logic [DATA_WIDTH-1:0]    readd1;
  logic [DATA_WIDTH-1:0]    readd2;
  logic [1:0]               Forward_A;
  logic [1:0]               Forward_B;
  logic [DATA_WIDTH-1:0]    WBData;
  logic [DATA_WIDTH-1:0]    Address;
  logic [DATA_WIDTH-1:0]    SignExtendOut;
  logic                     ALUSrc;
  logic                     RegDst;
  logic [REG_DIR_WIDTH-1:0] RegDst1;
  logic [REG_DIR_WIDTH-1:0] RegDst2;
  logic [1:0]               ALUop;
  logic [5:0]               funct;
  logic [PC_WIDTH-1:0]      PCnext;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic [DATA_WIDTH-1:0]    data2;
  logic [REG_DIR_WIDTH-1:0] WriteReg;
  logic                     Zero;
  logic [PC_WIDTH-1:0]      ALUR;
  logic [DATA_WIDTH-1:0]    HI;

  modport master (
    output in_valid, readd1, readd2, Forward_A, Forward_B, WBData, Address,
           SignExtendOut, ALUSrc, RegDst, RegDst1, RegDst2, ALUop, funct, PCnext,
    input  Stall, out_valid, ALUResult, data2, WriteReg, Zero, ALUR, HI
  );

  modport slave (
    input  in_valid, readd1, readd2, Forward_A, Forward_B, WBData, Address,
           SignExtendOut, ALUSrc, RegDst, RegDst1, RegDst2, ALUop, funct, PCnext,
    output Stall, out_valid, ALUResult, data2, WriteReg, Zero, ALUR, HI
  );
endinterface

// File: rtl/ex_mdu_stage.sv
// ex_mdu_stage
//   Execute stage with operand forwarding, a single-cycle ALU and an iterative
//   unsigned multiply/divide unit (one shift-add or restoring-subtract step per
//   cycle). Single-cycle ops retire one edge after acceptance; mult/div stall
//   the pipeline for DATA_WIDTH+1 cycles and retire from the DONE state.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ex_mdu_stage_if.slave (instruction fields in, Stall and EX/MEM
//          register outputs out)
module ex_mdu_stage #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_DIR_WIDTH = 3,
  parameter int PC_WIDTH      = 6
) (
  input  logic          clk,
  input  logic          rst,
  ex_mdu_stage_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_n;

  logic [W-1:0]             fwd_a, fwd_b, opb, alu_res;
  logic                     slt;
  logic                     is_muldiv;
  logic [REG_DIR_WIDTH-1:0] wr_sel;
  logic [PC_WIDTH+W-1:0]    alur_full;
  logic [PC_WIDTH-1:0]      alur_sum;

  // Iterative unit: acc_hi is the upper accumulator (product high / partial
  // remainder), lo_r the multiplier / dividend being shifted through and
  // finally the product low half / quotient. m_r holds multiplicand/divisor.
  logic [W-1:0]             acc_hi, lo_r, m_r;
  logic                     op_div;
  logic [CW-1:0]            cnt;
  logic [REG_DIR_WIDTH-1:0] held_wr;
  logic [PC_WIDTH-1:0]      held_alur;
  logic [W-1:0]             held_d2;

  logic [W:0]               m_sum;
  logic [W:0]               shifted;
  logic                     div_ge;
  logic [W-1:0]             rem_sub;
  logic [W-1:0]             step_hi, step_lo;

  // Operand forwarding; select 3 bypasses the stage's own registered result.
  always_comb begin
    unique case (bus.Forward_A)
      2'd0:    fwd_a = bus.readd1;
      2'd1:    fwd_a = bus.WBData;
      2'd2:    fwd_a = bus.Address;
      default: fwd_a = bus.ALUResult;
    endcase
    unique case (bus.Forward_B)
      2'd0:    fwd_b = bus.readd2;
      2'd1:    fwd_b = bus.WBData;
      2'd2:    fwd_b = bus.Address;
      default: fwd_b = bus.ALUResult;
    endcase
  end

  assign opb       = bus.ALUSrc ? bus.SignExtendOut : fwd_b;
  assign wr_sel    = bus.RegDst ? bus.RegDst1 : bus.RegDst2;
  assign slt       = $signed(fwd_a) < $signed(opb);
  assign is_muldiv = (bus.ALUop == 2'b10) &&
                     ((bus.funct == 6'h18) || (bus.funct == 6'h1A));
  assign alur_full = {{W{1'b0}}, bus.PCnext} + {{PC_WIDTH{1'b0}}, bus.SignExtendOut};
  assign alur_sum  = alur_full[PC_WIDTH-1:0];

  always_comb begin
    alu_res = '0;
    unique case (bus.ALUop)
      2'b00: alu_res = fwd_a + opb;
      2'b01: alu_res = fwd_a - opb;
      2'b11: alu_res = fwd_a | opb;
      default: begin
        case (bus.funct)
          6'h20:   alu_res = fwd_a + opb;
          6'h22:   alu_res = fwd_a - opb;
          6'h24:   alu_res = fwd_a & opb;
          6'h25:   alu_res = fwd_a | opb;
          6'h2A:   alu_res = {{(W-1){1'b0}}, slt};
          6'h10:   alu_res = bus.HI;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  // One mult or div iteration.
  // Mult: conditionally add multiplicand to the high half, then shift the
  // {carry, hi, lo} chain right by one.
  // Div: shift {rem, dividend} left by one and subtract the divisor when it
  // fits. Remainder and failed trials always stay below 2^W, so the subtract
  // is done modulo 2^W. A zero divisor always "fits", which yields an
  // all-ones quotient and the dividend as remainder with no special case.
  assign m_sum   = {1'b0, acc_hi} + (lo_r[0] ? {1'b0, m_r} : '0);
  assign shifted = {acc_hi, lo_r[W-1]};
  assign div_ge  = shifted >= {1'b0, m_r};
  assign rem_sub = shifted[W-1:0] - m_r;

  always_comb begin
    if (op_div) begin
      step_hi = div_ge ? rem_sub : shifted[W-1:0];
      step_lo = {lo_r[W-2:0], div_ge};
    end else begin
      step_hi = m_sum[W:1];
      step_lo = {m_sum[0], lo_r[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    bus.Stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && is_muldiv) begin
          bus.Stall = 1'b1;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        bus.Stall = 1'b1;
        if (cnt == CW'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.ALUResult <= '0;
      bus.data2     <= '0;
      bus.WriteReg  <= '0;
      bus.Zero      <= 1'b0;
      bus.ALUR      <= '0;
      bus.HI        <= '0;
      acc_hi        <= '0;
      lo_r          <= '0;
      m_r           <= '0;
      op_div        <= 1'b0;
      cnt           <= '0;
      held_wr       <= '0;
      held_alur     <= '0;
      held_d2       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && is_muldiv) begin
            bus.out_valid <= 1'b0;
            op_div        <= (bus.funct == 6'h1A);
            lo_r          <= fwd_a;
            m_r           <= opb;
            acc_hi        <= '0;
            cnt           <= CW'(W);
            held_wr       <= wr_sel;
            held_alur     <= alur_sum;
            held_d2       <= fwd_b;
          end else if (bus.in_valid) begin
            bus.out_valid <= 1'b1;
            bus.ALUResult <= alu_res;
            bus.Zero      <= (alu_res == '0);
            bus.data2     <= fwd_b;
            bus.WriteReg  <= wr_sel;
            bus.ALUR      <= alur_sum;
          end else begin
            bus.out_valid <= 1'b0;
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          lo_r   <= step_lo;
          cnt    <= cnt - CW'(1);
        end
        DONE: begin
          // Product and quotient both end in lo_r; high half and remainder in acc_hi.
          bus.out_valid <= 1'b1;
          bus.ALUResult <= lo_r;
          bus.Zero      <= (lo_r == '0);
          bus.HI        <= acc_hi;
          bus.data2     <= held_d2;
          bus.WriteReg  <= held_wr;
          bus.ALUR      <= held_alur;
        end
        default: bus.out_valid <= 1'b0;
      endcase
    end
  end
endmodule
